// File: rtl/axis_uart_word_tx.sv
// AXI-Stream word to UART serializer: accepts an N_BYTES-wide word and sends
// it byte 0 first, each byte framed as start(0), 8 data bits LSB first, stop(1).
module axis_uart_word_tx #(
    parameter int unsigned UART_SPEED = 115200,
    parameter int unsigned FREQ_HZ    = 100000000,
    parameter int unsigned N_BYTES    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_BYTES*8-1:0] S_AXIS_TDATA,
    input  logic                 S_AXIS_TVALID,
    output logic                 S_AXIS_TREADY,
    output logic                 UART_TX,
    output logic                 BUSY
);

    // Clocks per bit, guarded so a zero line rate fails the check below
    // rather than dividing by zero.
    localparam int unsigned D      = (UART_SPEED == 0) ? 0 : FREQ_HZ / UART_SPEED;
    localparam int unsigned DIV_W  = (D < 2) ? 1 : $clog2(D);
    localparam int unsigned BYTE_W = (N_BYTES < 2) ? 1 : $clog2(N_BYTES);
    localparam int unsigned WORD_W = N_BYTES * 8;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(D - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(N_BYTES - 1);

    if (D < 4 || FREQ_HZ == 0 || UART_SPEED == 0 || N_BYTES == 0) begin : g_param_check
        $error("axis_uart_word_tx: invalid parameters (need D >= 4, nonzero FREQ_HZ, UART_SPEED, N_BYTES)");
    end

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t              state, state_next;
    logic [DIV_W-1:0]    div_cnt, div_next;
    logic [2:0]          bit_idx, bit_next;
    logic [BYTE_W-1:0]   byte_idx, byte_next;
    logic [WORD_W-1:0]   shreg, sh_next;
    logic                tx_reg, tx_next;
    logic                bit_done;

    assign bit_done      = (div_cnt == DIV_LAST);
    assign S_AXIS_TREADY = (state == IDLE) && !reset;
    assign UART_TX       = tx_reg;
    assign BUSY          = (state != IDLE);

    // State, counters, shift register and the registered line output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            shreg    <= '0;
            tx_reg   <= 1'b1;
        end else begin
            state    <= state_next;
            div_cnt  <= div_next;
            bit_idx  <= bit_next;
            byte_idx <= byte_next;
            shreg    <= sh_next;
            tx_reg   <= tx_next;
        end
    end

    // Next-state logic; UART_TX is computed one cycle ahead so the line
    // changes exactly on bit boundaries. The shift register drops the sent
    // data bit each bit period, so the next byte lands in shreg[7:0].
    always_comb begin
        state_next = state;
        div_next   = bit_done ? '0 : div_cnt + 1'b1;
        bit_next   = bit_idx;
        byte_next  = byte_idx;
        sh_next    = shreg;
        tx_next    = tx_reg;
        unique case (state)
            IDLE: begin
                div_next = '0;
                tx_next  = 1'b1;
                if (S_AXIS_TVALID) begin
                    state_next = START;
                    sh_next    = S_AXIS_TDATA;
                    tx_next    = 1'b0;
                    bit_next   = '0;
                    byte_next  = '0;
                end
            end
            START: begin
                if (bit_done) begin
                    state_next = DATA;
                    tx_next    = shreg[0];
                    bit_next   = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    sh_next = shreg >> 1;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        bit_next = bit_idx + 3'd1;
                        tx_next  = shreg[1];
                    end
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (byte_idx == BYTE_LAST) begin
                        state_next = IDLE;
                        tx_next    = 1'b1;
                    end else begin
                        state_next = START;
                        tx_next    = 1'b0;
                        byte_next  = byte_idx + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

endmodule
